// File: rtl/uart_rx_async.sv
// uart_rx_async: 16x-oversampled asynchronous serial receiver.
//
// Recovers 7- or 8-bit frames with optional odd/even parity and one stop
// bit from an idle-high serial line. A received byte goes either to a
// holding register with a ready flag (RX_FIFO=0) or to an external FIFO
// through a one-clk active-low write strobe (RX_FIFO=1). Parity, framing
// and overrun errors are reported as sticky flags.
//
// Handshake: baud_clock is a one-clk enable; the receiver only advances on
// clk edges where it is high. Delivery is a single-clk event: rxrdy rises
// (or fifo_write_rx pulses low) on the clk edge of the stop-bit centre tick.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   baud_clock        16x baud enable pulse
//   rx                serial line (idles high)
//   bit8, parity_en,  frame format: 8/7 data bits, parity enable,
//   odd_n_even        odd(1)/even(0) parity
//   read_rx_byte      clears rxrdy (holding-register mode)
//   clear_err         clears the sticky error flags
//   fifo_full/_empty  external RX FIFO status (FIFO mode)
//   rx_byte, rxrdy    received data and availability
//   fifo_write_rx     active-low FIFO write strobe
//   parity_err, framing_err, overflow   sticky error flags
//   rx_state          debug view of the receive state machine
module uart_rx_async #(
  parameter int RX_FIFO     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       clear_err,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  output logic [7:0] rx_byte,
  output logic       rxrdy,
  output logic       fifo_write_rx,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic [2:0] rx_state
);

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    START_CHK  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [3:0]             samp_q, samp_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   rxrdy_q, rxrdy_d;
  logic                   wr_n_q, wr_n_d;
  logic                   pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
  logic                   deliver, pe_set, fe_set, ov_set;
  logic                   samp_wrap, last_bit;

  // Metastability chain; resets to the idle level so reset release is not
  // mistaken for a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign samp_wrap = (samp_q == 4'hF);
  assign last_bit  = bit8 ? (bit_cnt_q == 3'd7) : (bit_cnt_q == 3'd6);

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    rx_byte_d = rx_byte_q;
    rxrdy_d   = rxrdy_q;
    wr_n_d    = 1'b1;
    deliver   = 1'b0;
    pe_set    = 1'b0;
    fe_set    = 1'b0;
    ov_set    = 1'b0;

    if (baud_clock) begin
      case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            state_d   = START_CHK;
            samp_d    = 4'd0;
            bit_cnt_d = 3'd0;
            par_d     = 1'b0;
            // Cleared so bit 7 reads 0 in 7-bit mode.
            shift_d   = 8'h00;
          end
        end
        START_CHK: begin
          if (samp_q == 4'd7) begin
            if (!rx_s) begin
              state_d   = DATA_BITS;
              samp_d    = 4'd0;
              bit_cnt_d = 3'd0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
        DATA_BITS: begin
          samp_d = samp_q + 4'd1;
          if (samp_wrap) begin
            shift_d[bit_cnt_q] = rx_s;
            par_d              = par_q ^ rx_s;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (last_bit) state_d = parity_en ? PARITY_BIT : STOP_BIT;
          end
        end
        PARITY_BIT: begin
          samp_d = samp_q + 4'd1;
          if (samp_wrap) begin
            pe_set  = (rx_s != (odd_n_even ^ par_q));
            state_d = STOP_BIT;
          end
        end
        STOP_BIT: begin
          samp_d = samp_q + 4'd1;
          if (samp_wrap) begin
            fe_set  = !rx_s;
            deliver = 1'b1;
            // Back to idle at the stop-bit centre so a following start
            // bit is caught without losing half a bit.
            state_d = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end

    if (RX_FIFO == 0) begin
      if (deliver) begin
        rx_byte_d = shift_q;
        rxrdy_d   = 1'b1;
        ov_set    = rxrdy_q && !read_rx_byte;
      end else if (read_rx_byte) begin
        rxrdy_d = 1'b0;
      end
    end else begin
      rxrdy_d = !fifo_empty;
      if (deliver) begin
        if (fifo_full) begin
          ov_set = 1'b1;
        end else begin
          rx_byte_d = shift_q;
          wr_n_d    = 1'b0;
        end
      end
    end

    // A set in the same clk as clear_err wins.
    pe_d = pe_set | (pe_q & ~clear_err);
    fe_d = fe_set | (fe_q & ~clear_err);
    ov_d = ov_set | (ov_q & ~clear_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      samp_q    <= 4'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      rx_byte_q <= 8'h00;
      rxrdy_q   <= 1'b0;
      wr_n_q    <= 1'b1;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      rx_byte_q <= rx_byte_d;
      rxrdy_q   <= rxrdy_d;
      wr_n_q    <= wr_n_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rxrdy         = rxrdy_q;
  assign fifo_write_rx = wr_n_q;
  assign parity_err    = pe_q;
  assign framing_err   = fe_q;
  assign overflow      = ov_q;
  assign rx_state      = state_q;

endmodule

// File: tb/tb_uart_rx_async.sv
// Bench for uart_rx_async: one holding-register instance and one FIFO-mode
// instance share the serial line and frame format. A frame-level model
// predicts byte, ready and sticky flags for the holding-register instance;
// FIFO-mode writes are checked against an expected-byte queue.
module tb_uart_rx_async;

  localparam int BAUD_DIV = 4;
  localparam int BIT_CLKS = 16 * BAUD_DIV;

  logic       clk = 1'b0;
  logic       reset, baud_clock = 1'b0, rx;
  logic       bit8, parity_en, odd_n_even, read_rx_byte, clear_err;
  logic       fifo_full, fifo_empty;
  logic [7:0] rx_byte0, rx_byte1;
  logic       rxrdy0, rxrdy1, wr_n0, wr_n1;
  logic       pe0, pe1, fe0, fe1, ov0, ov1;
  logic [2:0] st0, st1;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level model of the holding-register instance
  logic [7:0] m_byte;
  logic       m_rdy, m_pe, m_fe, m_ov;

  // FIFO-mode scoreboard
  logic [7:0] exp_q[$];
  bit         fifo_phase = 1'b0;
  int         n_strobes  = 0;

  uart_rx_async #(.RX_FIFO(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .clear_err(clear_err),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .rx_byte(rx_byte0), .rxrdy(rxrdy0), .fifo_write_rx(wr_n0),
    .parity_err(pe0), .framing_err(fe0), .overflow(ov0), .rx_state(st0)
  );

  uart_rx_async #(.RX_FIFO(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .clear_err(clear_err),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .rx_byte(rx_byte1), .rxrdy(rxrdy1), .fifo_write_rx(wr_n1),
    .parity_err(pe1), .framing_err(fe1), .overflow(ov1), .rx_state(st1)
  );

  // ---------------- clock / reset / baud ----------------
  always #5 clk = ~clk;

  int unsigned bcnt = 0;
  always @(negedge clk) begin
    baud_clock = (bcnt == BAUD_DIV - 1);
    bcnt       = (bcnt + 1) % BAUD_DIV;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model0(input string tag);
    check({tag, ".rx_byte"},     32'(rx_byte0), 32'(m_byte));
    check({tag, ".rxrdy"},       32'(rxrdy0),   32'(m_rdy));
    check({tag, ".parity_err"},  32'(pe0),      32'(m_pe));
    check({tag, ".framing_err"}, 32'(fe0),      32'(m_fe));
    check({tag, ".overflow"},    32'(ov0),      32'(m_ov));
  endtask

  // FIFO-mode write monitor: each low sample is one write.
  always @(negedge clk) begin
    if (fifo_phase && !wr_n1) begin
      n_strobes++;
      check("fifo.q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("fifo.rx_byte", 32'(rx_byte1), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  function automatic logic data_xor(input logic [7:0] d, input logic b8);
    logic [7:0] m;
    m = b8 ? 8'hFF : 8'h7F;
    return ^(d & m);
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic pulse_read();
    @(negedge clk); read_rx_byte = 1'b1;
    @(negedge clk); read_rx_byte = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
  endtask

  // Start bit is dropped on the negedge after a baud tick, so the first low
  // sample is the tick 4 clks later and delivery lands 36 + 64*(bits after
  // the start bit) clks after the fall.
  task automatic send_frame(input logic [7:0] d, input logic b8, input logic pen,
                            input logic odd, input bit bad_par, input logic stop_v,
                            input bit rd_at_dlv, input bit meas_lat);
    int   n;
    int   dlv;
    logic pbit;
    n    = b8 ? 8 : 7;
    dlv  = 4 + 32 + BIT_CLKS * (n + (pen ? 1 : 0) + 1);
    pbit = odd ^ data_xor(d, b8) ^ bad_par;
    bit8 = b8; parity_en = pen; odd_n_even = odd;
    @(posedge clk iff baud_clock);
    @(negedge clk);
    fork
      begin
        drive_bit(1'b0);
        for (int i = 0; i < n; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stop_v);
        rx = 1'b1;
        // A low stop bit looks like a new start; let it be rejected.
        if (!stop_v) repeat (BIT_CLKS) @(negedge clk);
      end
      begin
        if (rd_at_dlv) begin
          repeat (dlv - 1) @(negedge clk);
          read_rx_byte = 1'b1;
          @(negedge clk);
          read_rx_byte = 1'b0;
        end
      end
      begin
        if (meas_lat) begin
          int c;
          c = 0;
          while (rxrdy0 !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
          end
          check("latency", 32'(c), 32'(dlv));
        end
      end
    join
  endtask

  // Sends a frame and updates the holding-register model from the frame rules.
  task automatic do_frame(input string tag, input logic [7:0] d, input logic b8,
                          input logic pen, input logic odd, input bit bad_par,
                          input logic stop_v, input bit rd_at_dlv, input bit meas_lat);
    send_frame(d, b8, pen, odd, bad_par, stop_v, rd_at_dlv, meas_lat);
    if (pen && bad_par) m_pe = 1'b1;
    if (!stop_v)        m_fe = 1'b1;
    if (m_rdy && !rd_at_dlv) m_ov = 1'b1;
    m_rdy  = 1'b1;
    m_byte = b8 ? d : {1'b0, d[6:0]};
    check_model0(tag);
  endtask

  task automatic model_read();
    pulse_read();
    m_rdy = 1'b0;
  endtask

  task automatic model_clear();
    pulse_clear();
    m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    m_byte = 8'h00; m_rdy = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    check_model0(tag);
    check({tag, ".wr_n0"},   32'(wr_n0),    32'd1);
    check({tag, ".state0"},  32'(st0),      32'd0);
    check({tag, ".rx_byte1"},32'(rx_byte1), 32'h00);
    check({tag, ".rxrdy1"},  32'(rxrdy1),   32'd0);
    check({tag, ".wr_n1"},   32'(wr_n1),    32'd1);
    check({tag, ".flags1"},  32'({pe1, fe1, ov1}), 32'd0);
  endtask

  task automatic fifo_frame(input string tag, input logic [7:0] d, input logic full);
    int s0;
    fifo_full = full;
    if (!full) exp_q.push_back(d);
    s0 = n_strobes;
    send_frame(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check({tag, ".strobes"},  32'(n_strobes - s0), full ? 32'd0 : 32'd1);
    check({tag, ".overflow"}, 32'(ov1), 32'(full));
    check({tag, ".pe_fe"},    32'({pe1, fe1}), 32'd0);
    fifo_full = 1'b0;
    if (full) pulse_clear();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    reset = 1'b1; rx = 1'b1; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    read_rx_byte = 1'b0; clear_err = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5 with delivery latency
    do_frame("8n1_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("8n1_a5.const", 32'(rx_byte0), 32'hA5);
    model_read();
    check("8n1_a5.read", 32'(rxrdy0), 32'd0);

    // 7E1 0x41 good, then bad parity, then clear
    do_frame("7e1_ok", 8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    model_read();
    do_frame("7e1_bad", 8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("7e1_bad.const", 32'(pe0), 32'd1);
    model_clear();
    check("7e1_clear", 32'(pe0), 32'd0);
    model_read();

    // 8O1 0x00 with low stop bit
    do_frame("8o1_fe", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("8o1_fe.state", 32'(st0), 32'd0);
    model_clear();
    model_read();

    // back-to-back, no read -> overrun; then with coincident read
    do_frame("b2b_1", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_frame("b2b_2", 8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("b2b.ov_const", 32'(ov0), 32'd1);
    model_clear();
    model_read();
    do_frame("b2b_rd1", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_frame("b2b_rd2", 8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("b2b_rd.ov_const", 32'(ov0), 32'd0);
    model_read();

    // start-bit glitch: low for 5 ticks
    @(posedge clk iff baud_clock);
    @(negedge clk);
    rx = 1'b0;
    repeat (5 * BAUD_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("glitch.state", 32'(st0), 32'd0);
    check_model0("glitch");

    // reset in the middle of bit 4
    do_frame("pre_rst", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    d = 8'h5A;
    bit8 = 1'b1; parity_en = 1'b0;
    @(posedge clk iff baud_clock);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (20) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("mid_rst");
    reset = 1'b0;
    repeat (8) @(negedge clk);
    do_frame("post_rst", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // randomized frames
    for (int k = 0; k < 20; k++) begin
      logic       b8, pen, odd, stop_v;
      bit         bad, rd_dlv;
      d      = 8'($urandom_range(0, 255));
      b8     = 1'($urandom_range(0, 1));
      pen    = 1'($urandom_range(0, 1));
      odd    = 1'($urandom_range(0, 1));
      bad    = ($urandom_range(0, 3) == 0);
      stop_v = ($urandom_range(0, 7) != 0);
      rd_dlv = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) model_read();
      if ($urandom_range(0, 3) == 0) model_clear();
      do_frame($sformatf("rand%0d", k), d, b8, pen, odd, bad, stop_v, rd_dlv, 1'b0);
    end

    // FIFO mode
    pulse_clear();
    fifo_empty = 1'b0;
    repeat (2) @(negedge clk);
    check("fifo.rxrdy_ne", 32'(rxrdy1), 32'd1);
    fifo_empty = 1'b1;
    repeat (2) @(negedge clk);
    check("fifo.rxrdy_e", 32'(rxrdy1), 32'd0);
    fifo_phase = 1'b1;
    fifo_frame("fifo_c3", 8'hC3, 1'b0);
    check("fifo_c3.byte", 32'(rx_byte1), 32'hC3);
    fifo_frame("fifo_3c_full", 8'h3C, 1'b1);
    for (int k = 0; k < 6; k++)
      fifo_frame($sformatf("fifo_rand%0d", k), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 2) == 0));
    fifo_phase = 1'b0;
    check("fifo.q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
